bus_memory_io: RTL and testbench

Memory/IO slave that sits directly downstream of the processor bus and produces rdata_bus.
- Consumes address_bus, control_bus {ram_read, ram_write} and wdata_bus.
- Returns rdata_bus for both instruction fetch and data load.
- Address map: 0x00-0xEF is word RAM; 0xF0-0xFF is a memory-mapped IO page with a transmit FIFO (drained by a valid/ready port) and a cycle timer with compare interrupt.

---
 rtl/bus_memory_io.sv | 131 +++++++++++++
 tb/tb_bus_memory_io.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_io.sv
// rtl/bus_memory_io.sv - word RAM plus IO page with TX FIFO and cycle timer
// Optional timer/compare block enabled by defining BUS_TIMER_EN.
module bus_memory_io #(
  parameter int    RAM_DEPTH  = 240,
  parameter int    FIFO_DEPTH = 4,
  parameter string RAM_INIT   = ""
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  address_bus,
  input  logic [1:0]  control_bus,
  input  logic [15:0] wdata_bus,
  output logic [15:0] rdata_bus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [8:0]     RAM_TOP  = 9'(RAM_DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  logic ram_read, ram_write, rd_en, ram_hit;
  logic wr_tx, wr_status;

  assign ram_read  = control_bus[1];
  assign ram_write = control_bus[0];
  // A simultaneous read+write request is a write; the read port stays quiet.
  assign rd_en     = ram_read & ~ram_write;
  assign ram_hit   = {1'b0, address_bus} < RAM_TOP;
  assign wr_tx     = ram_write && (address_bus == 8'hF0);
  assign wr_status = ram_write && (address_bus == 8'hF1);

  logic [15:0] ram [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (ram_write && ram_hit)
      ram[address_bus] <= wdata_bus;
  end

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic          overflow, full, empty, pop, push_ok, push_drop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign tx_valid  = ~empty;
  assign tx_data   = fifo[rptr];
  assign pop       = tx_valid & tx_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = wr_tx & (~full | pop);
  assign push_drop = wr_tx & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo[wptr] <= wdata_bus[7:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      if (push_drop)
        overflow <= 1'b1;
      else if (wr_status)
        overflow <= 1'b0;
    end
  end

  logic [15:0] timer_rd, cmp_rd;

`ifdef BUS_TIMER_EN
  logic [15:0] timer_q, cmp_q;
  logic        irq_q;
  logic        wr_timer, wr_cmp;

  assign wr_timer = ram_write && (address_bus == 8'hF2);
  assign wr_cmp   = ram_write && (address_bus == 8'hF3);

  // The match uses the pre-edge count, so a load equal to compare fires one cycle later.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      timer_q <= 16'h0000;
      cmp_q   <= 16'hFFFF;
      irq_q   <= 1'b0;
    end else begin
      irq_q   <= (timer_q == cmp_q);
      timer_q <= wr_timer ? wdata_bus : timer_q + 16'd1;
      if (wr_cmp)
        cmp_q <= wdata_bus;
    end
  end

  assign timer_irq = irq_q;
  assign timer_rd  = timer_q;
  assign cmp_rd    = cmp_q;
`else
  assign timer_irq = 1'b0;
  assign timer_rd  = 16'h0000;
  assign cmp_rd    = 16'h0000;
`endif

  always_comb begin
    rdata_bus = 16'h0000;
    if (rd_en) begin
      if (ram_hit)
        rdata_bus = ram[address_bus];
      else begin
        case (address_bus)
          8'hF0:   rdata_bus = {{(16-CW){1'b0}}, count};
          8'hF1:   rdata_bus = {13'b0, overflow, full, empty};
          8'hF2:   rdata_bus = timer_rd;
          8'hF3:   rdata_bus = cmp_rd;
          default: rdata_bus = 16'h0000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_memory_io.sv
// tb/tb_bus_memory_io.sv - self-checking bench for bus_memory_io (timer checks under BUS_TIMER_EN)
module tb_bus_memory_io;

  localparam int DEPTH = 4;
`ifdef BUS_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [7:0]  address_bus = 8'h00;
  logic [1:0]  control_bus = 2'b00;
  logic [15:0] wdata_bus = 16'h0000;
  logic        tx_ready = 1'b0;
  logic [15:0] rdata_bus;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        timer_irq;

  bus_memory_io #(.RAM_DEPTH(240), .FIFO_DEPTH(DEPTH), .RAM_INIT("")) dut (
    .clk(clk), .nreset(nreset), .address_bus(address_bus), .control_bus(control_bus),
    .wdata_bus(wdata_bus), .rdata_bus(rdata_bus), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: a byte queue, sticky flag, integer-style timer and a sparse RAM.
  byte unsigned q[$];
  bit           ovf_m = 1'b0;
  logic [15:0]  timer_m = 16'h0000;
  logic [15:0]  cmp_m = 16'hFFFF;
  bit           irq_m = 1'b0;
  logic [15:0]  ram_m [int];

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      q.delete();
      ovf_m   = 1'b0;
      timer_m = 16'h0000;
      cmp_m   = 16'hFFFF;
      irq_m   = 1'b0;
    end else begin
      bit wr;
      bit pop;
      wr    = control_bus[0];
      pop   = (q.size() != 0) && tx_ready;
      irq_m = TEN && (timer_m == cmp_m);
      if (wr && address_bus == 8'hF2) timer_m = wdata_bus;
      else timer_m = timer_m + 16'd1;
      if (wr && address_bus == 8'hF3) cmp_m = wdata_bus;
      if (pop) void'(q.pop_front());
      if (wr && address_bus == 8'hF0) begin
        if (q.size() < DEPTH) q.push_back(wdata_bus[7:0]);
        else ovf_m = 1'b1;
      end else if (wr && address_bus == 8'hF1) begin
        ovf_m = 1'b0;
      end
      if (wr && address_bus < 8'hF0) ram_m[int'(address_bus)] = wdata_bus;
    end
  end

  function automatic bit exp_rdata(output logic [15:0] v);
    v = 16'h0000;
    if (control_bus == 2'b10) begin
      if (address_bus < 8'hF0) begin
        if (!ram_m.exists(int'(address_bus))) return 1'b0;
        v = ram_m[int'(address_bus)];
      end else begin
        case (address_bus)
          8'hF0:   v = 16'(q.size());
          8'hF1:   v = {13'b0, ovf_m, q.size() == DEPTH, q.size() == 0};
          8'hF2:   v = TEN ? timer_m : 16'h0000;
          8'hF3:   v = TEN ? cmp_m : 16'h0000;
          default: v = 16'h0000;
        endcase
      end
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      logic [15:0] ev;
      if (exp_rdata(ev)) check("cmp_rdata", rdata_bus, ev);
      check("cmp_tx_valid", {15'b0, tx_valid}, {15'b0, q.size() != 0});
      if (q.size() != 0) check("cmp_tx_data", {8'b0, tx_data}, {8'b0, q[0]});
      check("cmp_timer_irq", {15'b0, timer_irq}, {15'b0, irq_m});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] a, input logic [15:0] d);
    control_bus = c;
    address_bus = a;
    wdata_bus   = d;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    drive(2'b01, a, d);
    tick;
    drive(2'b00, 8'h00, 16'h0000);
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [15:0] exp);
    drive(2'b10, a, 16'h0000);
    #1;
    check(nm, rdata_bus, exp);
    tick;
    drive(2'b00, 8'h00, 16'h0000);
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    nreset  = 1'b1;
    run_cmp = 1'b1;

    rd("timer_after_reset", 8'hF2, 16'h0000);
    rd("status_reset", 8'hF1, 16'h0001);
    check("valid_reset", {15'b0, tx_valid}, 16'h0000);
    check("irq_reset", {15'b0, timer_irq}, 16'h0000);

    wr(8'h10, 16'hBEEF);
    rd("ram_read", 8'h10, 16'hBEEF);
    drive(2'b11, 8'h10, 16'hBEEF);
    #1;
    check("ram_rw11", rdata_bus, 16'h0000);
    tick;
    wr(8'hF7, 16'h1234);
    rd("io_unused", 8'hF7, 16'h0000);

    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'hF0, 16'h0041 + 16'(i));
    rd("occ_full", 8'hF0, 16'h0004);
    rd("status_ovf_full", 8'hF1, 16'h0006);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {15'b0, tx_valid}, 16'h0001);
      check("drain_data", {8'b0, tx_data}, 16'h0041 + 16'(i));
      tick;
    end
    check("drain_empty", {15'b0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;
    rd("status_ovf_empty", 8'hF1, 16'h0005);
    wr(8'hF1, 16'h0000);
    rd("status_cleared", 8'hF1, 16'h0001);

    for (int i = 0; i < 4; i++) wr(8'hF0, 16'h0051 + 16'(i));
    tx_ready = 1'b1;
    wr(8'hF0, 16'h0055);
    tx_ready = 1'b0;
    rd("occ_push_pop", 8'hF0, 16'h0004);
    rd("status_push_pop", 8'hF1, 16'h0002);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pp_data", {8'b0, tx_data}, 16'h0052 + 16'(i));
      tick;
    end
    check("pp_empty", {15'b0, tx_valid}, 16'h0000);

    wr(8'hF0, 16'h0066);
    check("empty_push_pop_valid", {15'b0, tx_valid}, 16'h0001);
    check("empty_push_pop_data", {8'b0, tx_data}, 16'h0066);
    tick;
    tx_ready = 1'b0;

`ifdef BUS_TIMER_EN
    wr(8'hF2, 16'h0100);
    wr(8'hF3, 16'h0010);
    wr(8'hF2, 16'h000C);
    for (int k = 1; k <= 6; k++) begin
      tick;
      check("irq_after_load", {15'b0, timer_irq}, 16'(k == 5));
    end
    wr(8'hF2, 16'h0010);
    check("irq_load_eq_same", {15'b0, timer_irq}, 16'h0000);
    tick;
    check("irq_load_eq_next", {15'b0, timer_irq}, 16'h0001);
    wr(8'hF2, 16'hFFFE);
    tick;
    drive(2'b10, 8'hF2, 16'h0000);
    #1;
    check("timer_ffff", rdata_bus, 16'hFFFF);
    tick;
    check("timer_wrap", rdata_bus, 16'h0000);
    drive(2'b00, 8'h00, 16'h0000);
    tick;
`endif

    for (int i = 0; i < 5; i++) wr(8'hF0, 16'h0071 + 16'(i));
    tx_ready = 1'b1;
    tick;
    tx_ready = 1'b0;
    check("three_queued", {15'b0, tx_valid}, 16'h0001);
    #2;
    nreset = 1'b0;
    #1;
    check("async_reset_valid", {15'b0, tx_valid}, 16'h0000);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    rd("occ_after_reset", 8'hF0, 16'h0000);
    rd("status_after_reset", 8'hF1, 16'h0001);

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
